// File: rtl/contador_lector_if.sv
// Read-protocol bus between the sweep initiator and the counters block.
// The master issues request/select; the slave answers with valid/contador.
interface contador_lector_if #(
    parameter int CNT_W = 3
);
    logic             request;
    logic [1:0]       select;
    logic [CNT_W-1:0] contador;
    logic             valid;

    modport master (
        output request,
        output select,
        input  contador,
        input  valid
    );

    modport slave (
        input  request,
        input  select,
        output contador,
        output valid
    );
endinterface

// File: rtl/contador_lector.sv
// Sweeps the four FIFO pop counters, captures each count, sums them
// and flags a timeout when the counters block fails to answer.
module contador_lector #(
    parameter int CNT_W    = 3,
    parameter int TIMEOUT  = 7,
    parameter int NUM_FIFO = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  start,
    input  logic                  idle_in,
    contador_lector_if.master     bus,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1,
    output logic [CNT_W-1:0]      cnt2,
    output logic [CNT_W-1:0]      cnt3,
    output logic [CNT_W+1:0]      total,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);
    localparam int          TW     = CNT_W + 2;
    localparam logic [3:0]  TO_LIM = 4'(TIMEOUT);
    localparam logic [1:0]  LAST   = 2'(NUM_FIFO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_REQ,
        S_WAIT_VLD,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q [NUM_FIFO];
    logic [CNT_W-1:0] cnt_d [NUM_FIFO];
    logic [TW-1:0]    total_q, total_d;
    logic             to_q, to_d;
    logic [3:0]       wait_inc;
    logic [TW-1:0]    sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            sum = sum + TW'(cnt_q[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wait_d   = wait_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        to_d     = to_q;
        wait_inc = wait_q + 4'd1;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    to_d    = 1'b0;
                    sel_d   = '0;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (idle_in) state_d = S_REQ;
            end
            S_REQ: begin
                wait_d  = '0;
                state_d = S_WAIT_VLD;
            end
            S_WAIT_VLD: begin
                // A response on the last allowed cycle still wins.
                if (bus.valid) begin
                    cnt_d[sel_q] = bus.contador;
                    state_d      = S_NEXT;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == TO_LIM) begin
                        to_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_NEXT: begin
                if (sel_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    sel_d   = sel_q + 2'd1;
                    state_d = idle_in ? S_REQ : S_WAIT_IDLE;
                end
            end
            S_DONE: begin
                total_d = sum;
                sel_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            wait_q  <= '0;
            cnt_q   <= '{default: '0};
            total_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            to_q    <= to_d;
        end
    end

    assign bus.request = (state_q == S_REQ);
    assign bus.select  = sel_q;
    assign cnt0        = cnt_q[0];
    assign cnt1        = cnt_q[1];
    assign cnt2        = cnt_q[2];
    assign cnt3        = cnt_q[3];
    assign total       = total_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign timeout_err = to_q;
endmodule

// File: tb/tb_contador_lector.sv
// Bench for contador_lector: directed table sweeps, corner sequences
// and randomized sweeps against a per-sweep behavioural model.
module tb_contador_lector;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_L, start, idle_in;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
    logic [CNT_W+1:0] total;
    logic             busy, done, timeout_err;
    logic             rsp_valid;
    logic [CNT_W-1:0] rsp_cnt;

    contador_lector_if #(.CNT_W(CNT_W)) bus ();
    assign bus.valid    = rsp_valid;
    assign bus.contador = rsp_cnt;

    contador_lector #(
        .CNT_W(CNT_W),
        .TIMEOUT(7),
        .NUM_FIFO(4)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .start(start),
        .idle_in(idle_in),
        .bus(bus),
        .cnt0(cnt0),
        .cnt1(cnt1),
        .cnt2(cnt2),
        .cnt3(cnt3),
        .total(total),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [3:0][2:0] vals;
        logic [3:0]      ans;
        int dly, rs;
        int e_c0, e_c1, e_c2, e_c3, e_tot, e_to, e_done, e_nreq;
    } vec_t;

    int nvec = 0;
    int nmis = 0;
    int r_sel[$];
    int r_done_cyc, r_done_n, r_bad_idle;
    int m_cnt[4];
    int m_to, m_nreq, m_tot;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sweep outcome from the protocol rules: read counters in order,
    // abort at the first one that never answers.
    task automatic model(input logic [3:0][2:0] vals, input logic [3:0] ans);
        m_to   = 0;
        m_nreq = 0;
        for (int s = 0; s < 4; s++) begin
            m_nreq++;
            if (ans[s]) m_cnt[s] = int'(vals[s]);
            else begin
                m_to = 1;
                break;
            end
        end
        m_tot = m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3];
    endtask

    // Runs one sweep; the bench plays the counters block, answering
    // one cycle after each request when ans[select] is set.
    task automatic sweep(input logic [3:0][2:0] vals, input logic [3:0] ans,
                         input int idle_dly, input int restart_at,
                         input int rst_at, input bit rnd_idle);
        logic       pend;
        logic [2:0] pval;
        bit         prev_idle;
        bit         stop;
        r_sel.delete();
        r_done_cyc = -1;
        r_done_n   = 0;
        r_bad_idle = 0;
        pend = 1'b0;
        pval = '0;
        prev_idle = 1'b0;
        stop = 1'b0;
        start = 1'b1;
        idle_in = rnd_idle ? ($urandom_range(0, 3) != 0) : (idle_dly == 0);
        for (int cyc = 0; cyc < 200 && !stop; cyc++) begin
            if (cyc > 0) begin
                start = (cyc == restart_at);
                idle_in = rnd_idle ? ($urandom_range(0, 3) != 0)
                                   : (cyc > idle_dly);
                rsp_valid = pend;
                rsp_cnt   = pend ? pval : '0;
                pend      = 1'b0;
            end
            if (cyc == rst_at) reset_L = 1'b0;
            @(negedge clk);
            if (bus.request) begin
                r_sel.push_back(int'(bus.select));
                if (!prev_idle) r_bad_idle++;
                if (ans[bus.select]) begin
                    pend = 1'b1;
                    pval = vals[bus.select];
                end
            end
            prev_idle = idle_in;
            if (done) begin
                r_done_n++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            if (cyc == 1) check("busy_in_sweep", busy, 1);
            step();
            if (cyc == rst_at || r_done_n > 0) stop = 1'b1;
        end
        start     = 1'b0;
        rsp_valid = 1'b0;
        rsp_cnt   = '0;
        if (rst_at < 0) begin
            check("done_seen", r_done_n, 1);
            check("done_single_cycle", done, 0);
            check("busy_after_done", busy, 0);
        end
    endtask

    task automatic check_order(input int n);
        check("request_count", r_sel.size(), n);
        for (int k = 0; k < r_sel.size(); k++) check("request_select", r_sel[k], k);
        check("request_idle_ok", r_bad_idle, 0);
    endtask

    task automatic check_model();
        check("cnt0", cnt0, m_cnt[0]);
        check("cnt1", cnt1, m_cnt[1]);
        check("cnt2", cnt2, m_cnt[2]);
        check("cnt3", cnt3, m_cnt[3]);
        check("total", total, m_tot);
        check("timeout_err", timeout_err, m_to);
        check_order(m_nreq);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cnt0"}, cnt0, 0);
        check({tag, "_cnt1"}, cnt1, 0);
        check({tag, "_cnt2"}, cnt2, 0);
        check({tag, "_cnt3"}, cnt3, 0);
        check({tag, "_total"}, total, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout"}, timeout_err, 0);
        check({tag, "_request"}, bus.request, 0);
        check({tag, "_select"}, bus.select, 0);
    endtask

    vec_t tbl[5];

    initial begin
        logic [3:0][2:0] rv;
        logic [3:0]      ra;
        tbl[0] = '{{3'd7, 3'd0, 3'd5, 3'd3}, 4'b1111, 0, 0,
                   3, 5, 0, 7, 15, 0, 14, 4};
        tbl[1] = '{{3'd4, 3'd3, 3'd2, 3'd1}, 4'b1111, 6, 0,
                   1, 2, 3, 4, 10, 0, 20, 4};
        tbl[2] = '{{3'd6, 3'd6, 3'd6, 3'd6}, 4'b1011, 0, 0,
                   6, 6, 3, 4, 19, 1, 16, 3};
        tbl[3] = '{{3'd7, 3'd7, 3'd7, 3'd7}, 4'b1111, 0, 6,
                   7, 7, 7, 7, 28, 0, 14, 4};
        tbl[4] = '{{3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 0, 0,
                   7, 7, 7, 7, 28, 1, 10, 1};

        reset_L = 1'b0;
        start = 1'b0;
        idle_in = 1'b0;
        rsp_valid = 1'b0;
        rsp_cnt = '0;
        step();
        step();
        check_zero("reset");
        reset_L = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            sweep(tbl[i].vals, tbl[i].ans, tbl[i].dly, tbl[i].rs, -1, 1'b0);
            model(tbl[i].vals, tbl[i].ans);
            check("done_cycle", r_done_cyc, tbl[i].e_done);
            check("tbl_cnt0", cnt0, tbl[i].e_c0);
            check("tbl_cnt1", cnt1, tbl[i].e_c1);
            check("tbl_cnt2", cnt2, tbl[i].e_c2);
            check("tbl_cnt3", cnt3, tbl[i].e_c3);
            check("tbl_total", total, tbl[i].e_tot);
            check("tbl_timeout", timeout_err, tbl[i].e_to);
            check_order(tbl[i].e_nreq);
            step();
        end

        // Unsolicited response while idle must not touch any count.
        rsp_valid = 1'b1;
        rsp_cnt = 3'd6;
        step();
        rsp_valid = 1'b0;
        rsp_cnt = '0;
        step();
        check("idle_valid_busy", busy, 0);
        check_model();

        // Reset while waiting on select=1, then a clean sweep.
        sweep({3'd1, 3'd2, 3'd3, 3'd4}, 4'b1101, 0, 0, 7, 1'b0);
        check("pre_reset_requests", r_sel.size(), 2);
        check_zero("midreset");
        reset_L = 1'b1;
        for (int s = 0; s < 4; s++) m_cnt[s] = 0;
        step();
        sweep({3'd2, 3'd6, 3'd1, 3'd5}, 4'b1111, 0, 0, -1, 1'b0);
        model({3'd2, 3'd6, 3'd1, 3'd5}, 4'b1111);
        check("post_reset_done_cycle", r_done_cyc, 14);
        check_model();
        step();

        for (int n = 0; n < 20; n++) begin
            for (int s = 0; s < 4; s++) begin
                rv[s] = 3'($urandom_range(0, 7));
                ra[s] = ($urandom_range(0, 4) != 0);
            end
            sweep(rv, ra, 0, 0, -1, 1'b1);
            model(rv, ra);
            check_model();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
